neuron_mac: RTL and testbench

NEURON_MAC -- requirements
Module: neuron_mac

---
 rtl/neuron_mac.sv | 156 +++++++++++++++
 tb/tb_neuron_mac.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac.sv
// Single-neuron multiply-accumulate: streams inputs against a weight memory,
// accumulates with saturation, then adds bias and applies ReLU per frame.
module neuron_mac #(
   parameter int numWeight    = 30,
   parameter int dataWidth    = 16,
   parameter int fracBits     = 12,
   parameter int addressWidth = $clog2(numWeight)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [dataWidth-1:0]    myinput,
   input  logic                    myinputValid,
   output logic                    myinputReady,
   output logic                    ren,
   output logic [addressWidth-1:0] radd,
   input  logic [dataWidth-1:0]    wout,
   input  logic [dataWidth-1:0]    bias,
   output logic [dataWidth-1:0]    out,
   output logic                    outvalid
);

   localparam int AccW = 2 * dataWidth;
   localparam logic signed [AccW-1:0] AccMax = {1'b0, {(AccW-1){1'b1}}};
   localparam logic signed [AccW-1:0] AccMin = {1'b1, {(AccW-1){1'b0}}};
   localparam logic signed [AccW-1:0] OutMaxWide =
      {{(AccW-dataWidth+1){1'b0}}, {(dataWidth-1){1'b1}}};
   localparam logic [addressWidth-1:0] LastAddr = addressWidth'(numWeight - 1);

   typedef enum logic {ACCUM, DRAIN} state_t;

   function automatic logic signed [AccW-1:0] sat_add(
      input logic signed [AccW-1:0] a,
      input logic signed [AccW-1:0] b
   );
      logic signed [AccW:0] sum;
      sum = $signed({a[AccW-1], a}) + $signed({b[AccW-1], b});
      if (sum[AccW] != sum[AccW-1]) begin
         return sum[AccW] ? AccMin : AccMax;
      end
      return sum[AccW-1:0];
   endfunction

   function automatic logic [dataWidth-1:0] relu_sat(input logic signed [AccW-1:0] s);
      logic signed [AccW-1:0] sh;
      sh = s >>> fracBits;
      if (s[AccW-1]) begin
         return '0;
      end
      if (sh > OutMaxWide) begin
         return OutMaxWide[dataWidth-1:0];
      end
      return sh[dataWidth-1:0];
   endfunction

   state_t                   state_q, state_d;
   logic [addressWidth-1:0]  cnt_q, cnt_d;
   logic [1:0]               drain_q, drain_d;
   logic signed [dataWidth-1:0] in_p1_q, in_p1_d;
   logic                     vld_p1_q, vld_p1_d;
   logic signed [AccW-1:0]   prod_p2_q, prod_p2_d;
   logic                     vld_p2_q, vld_p2_d;
   logic signed [AccW-1:0]   acc_q, acc_d;
   logic [dataWidth-1:0]     out_q, out_d;
   logic                     outvalid_q, outvalid_d;

   logic                     accept;
   logic signed [dataWidth-1:0] wout_s;
   logic signed [AccW-1:0]   bias_ext;
   logic signed [AccW-1:0]   bias_sh;

   assign wout_s       = wout;
   assign bias_ext     = {{dataWidth{bias[dataWidth-1]}}, bias};
   assign bias_sh      = bias_ext <<< fracBits;
   assign myinputReady = (state_q == ACCUM);
   assign accept       = myinputValid & myinputReady;
   assign ren          = accept;
   assign radd         = cnt_q;
   assign out          = out_q;
   assign outvalid     = outvalid_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      drain_d    = drain_q;
      acc_d      = acc_q;
      out_d      = out_q;
      outvalid_d = 1'b0;

      // p1: capture accepted activation; weight arrives one cycle later
      in_p1_d  = myinput;
      vld_p1_d = accept;

      // p2: full-precision product
      prod_p2_d = in_p1_q * wout_s;
      vld_p2_d  = vld_p1_q;

      // accumulate stage
      if (vld_p2_q) begin
         acc_d = sat_add(acc_q, prod_p2_q);
      end

      case (state_q)
         ACCUM: begin
            if (accept) begin
               if (cnt_q == LastAddr) begin
                  cnt_d   = '0;
                  drain_d = '0;
                  state_d = DRAIN;
               end else begin
                  cnt_d = cnt_q + addressWidth'(1);
               end
            end
         end
         DRAIN: begin
            // Three drain cycles let the last product clear p1, p2 and acc.
            if (drain_q == 2'd2) begin
               out_d      = relu_sat(sat_add(acc_q, bias_sh));
               outvalid_d = 1'b1;
               acc_d      = '0;
               state_d    = ACCUM;
            end else begin
               drain_d = drain_q + 2'd1;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ACCUM;
         cnt_q      <= '0;
         drain_q    <= '0;
         vld_p1_q   <= 1'b0;
         vld_p2_q   <= 1'b0;
         acc_q      <= '0;
         out_q      <= '0;
         outvalid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         drain_q    <= drain_d;
         vld_p1_q   <= vld_p1_d;
         vld_p2_q   <= vld_p2_d;
         acc_q      <= acc_d;
         out_q      <= out_d;
         outvalid_q <= outvalid_d;
      end
   end

   always_ff @(posedge clk) begin
      in_p1_q   <= in_p1_d;
      prod_p2_q <= prod_p2_d;
   end

endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac: frames driven against a 1-cycle-latency
// weight memory; expected outputs and due cycles queued, checked on outvalid.
module tb_neuron_mac;

   localparam int NW = 30;
   localparam int DW = 16;
   localparam int AW = $clog2(NW);

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] myinput;
   logic          myinputValid;
   logic          myinputReady;
   logic          ren;
   logic [AW-1:0] radd;
   logic [DW-1:0] wout;
   logic [DW-1:0] bias;
   logic [DW-1:0] out;
   logic          outvalid;

   neuron_mac #(.numWeight(NW), .dataWidth(DW), .fracBits(12)) dut (
      .clk(clk), .rst(rst), .myinput(myinput), .myinputValid(myinputValid),
      .myinputReady(myinputReady), .ren(ren), .radd(radd), .wout(wout),
      .bias(bias), .out(out), .outvalid(outvalid)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] wmem [0:NW-1];
   always @(posedge clk) if (ren) wout <= wmem[radd];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [DW-1:0] val;
      int            due;
   } exp_t;
   exp_t sbq[$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [DW-1:0] model_out(input logic [DW-1:0] x,
                                                input logic [DW-1:0] w,
                                                input logic [DW-1:0] b);
      longint a = 0;
      longint s;
      longint hi = 64'sd2147483647;
      longint lo = -64'sd2147483648;
      for (int i = 0; i < NW; i++) begin
         a = a + longint'($signed(x)) * longint'($signed(w));
         if (a > hi) a = hi;
         if (a < lo) a = lo;
      end
      s = a + longint'($signed(b)) * 4096;
      if (s > hi) s = hi;
      if (s < lo) s = lo;
      if (s < 0) return '0;
      s = s / 4096;
      if (s > 32767) return 16'h7FFF;
      return s[DW-1:0];
   endfunction

   // Every outvalid pulse must match the head of the scoreboard at its due cycle.
   always @(negedge clk) begin
      if (outvalid) begin
         if (sbq.size() == 0) begin
            check("unexpected_outvalid", {16'h0, out}, 32'hDEAD);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            check("out", {16'h0, out}, {16'h0, e.val});
            check("latency", cyc, e.due);
         end
      end
   end

   task automatic send_frame(input logic [DW-1:0] x, input logic [DW-1:0] w,
                             input logic [DW-1:0] b, input bit gapped,
                             input bit noise, input int n);
      int  k = 0;
      bit  tog = 1'b0;
      bit  acc;
      int  last_c = 0;
      for (int i = 0; i < NW; i++) wmem[i] = w;
      bias         = b;
      myinput      = x;
      myinputValid = gapped ? tog : 1'b1;
      while (k < n) begin
         @(negedge clk);
         acc = myinputValid && myinputReady;
         check("ready_accum", {31'h0, myinputReady}, 32'h1);
         check("ren", {31'h0, ren}, {31'h0, acc});
         if (acc) check("radd", {27'h0, radd}, k);
         if (acc && k == n - 1) last_c = cyc;
         @(posedge clk);
         #1;
         if (acc) k++;
         if (gapped) tog = !tog;
         myinputValid = (k < n) ? (gapped ? tog : 1'b1) : 1'b0;
      end
      if (n == NW) begin
         sbq.push_back('{val: model_out(x, w, b), due: last_c + 4});
         myinputValid = noise;
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ready_drain", {31'h0, myinputReady}, 32'h0);
            check("ren_drain", {31'h0, ren}, 32'h0);
            @(posedge clk);
            #1;
         end
         myinputValid = 1'b0;
         @(negedge clk);
         check("ready_after", {31'h0, myinputReady}, 32'h1);
         for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
         check("output_timeout", sbq.size(), 0);
         sbq.delete();
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b1;
      myinput      = '0;
      myinputValid = 1'b0;
      bias         = '0;
      for (int i = 0; i < NW; i++) wmem[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_out", {16'h0, out}, 32'h0);
      check("rst_outvalid", {31'h0, outvalid}, 32'h0);
      check("rst_ready", {31'h0, myinputReady}, 32'h1);
      check("rst_ren", {31'h0, ren}, 32'h0);
      @(posedge clk);
      #1;

      send_frame(16'h1000, 16'h0100, 16'h0000, 1'b0, 1'b0, NW);
      check("basic_value", {16'h0, out}, 32'h1E00);
      send_frame(16'h1000, 16'hF000, 16'h1000, 1'b0, 1'b0, NW);
      check("relu_value", {16'h0, out}, 32'h0);
      send_frame(16'h1000, 16'h0100, 16'h0000, 1'b1, 1'b1, NW);
      check("gapped_value", {16'h0, out}, 32'h1E00);
      send_frame(16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0, NW);
      check("sat_value", {16'h0, out}, 32'h7FFF);
      send_frame(16'h0100, 16'h0200, 16'hFF00, 1'b0, 1'b0, NW);
      check("negbias_value", {16'h0, out}, 32'h02C0);

      send_frame(16'h1000, 16'h0100, 16'h0000, 1'b0, 1'b0, 10);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_out", {16'h0, out}, 32'h0);
      check("midrst_outvalid", {31'h0, outvalid}, 32'h0);
      check("midrst_ready", {31'h0, myinputReady}, 32'h1);
      repeat (5) @(negedge clk);
      @(posedge clk);
      #1;
      send_frame(16'h1000, 16'h0100, 16'h0000, 1'b0, 1'b0, NW);
      check("post_rst_value", {16'h0, out}, 32'h1E00);

      repeat (5) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
